// File: rtl/alu_op_sequencer_if.sv
// Handshake and datapath-strobe bundle between the ALU op sequencer
// and the bus datapath it controls.
interface alu_op_sequencer_if #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 5,
    parameter int RADDR_W = 4
);
    logic [DATA_W-1:0]  instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [OP_W-1:0]    op_code;
    logic [RADDR_W-1:0] rd_sel;
    logic               rd_en;
    logic [DATA_W-1:0]  imm_out;
    logic               imm_en;
    logic               y_in;
    logic               z_in;
    logic               zlo_out;
    logic               zhi_out;
    logic [RADDR_W-1:0] wr_sel;
    logic               wr_en;
    logic               lo_in;
    logic               hi_in;
    logic               done;
    logic               err;

    modport master (
        output instr, instr_valid,
        input  instr_ready, op_code, rd_sel, rd_en, imm_out, imm_en,
        input  y_in, z_in, zlo_out, zhi_out, wr_sel, wr_en,
        input  lo_in, hi_in, done, err
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, op_code, rd_sel, rd_en, imm_out, imm_en,
        output y_in, z_in, zlo_out, zhi_out, wr_sel, wr_en,
        output lo_in, hi_in, done, err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU-class instruction sequencer: latches one instruction and steps the
// bus strobes through T3..T6 (operand to Y, ALU op into Z, Z writeback).
module alu_op_sequencer #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 5,
    parameter int RADDR_W = 4,
    parameter int IMM_W   = 19
) (
    input logic clk,
    input logic clr,
    alu_op_sequencer_if.slave bus
);
    localparam int RA_HI = DATA_W - OP_W - 1;
    localparam int RB_HI = RA_HI - RADDR_W;
    localparam int RC_HI = RB_HI - RADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_T3, S_T4, S_T5, S_T6, S_ERR
    } state_t;

    typedef enum logic [2:0] {
        K_R, K_I, K_U, K_M, K_BAD
    } kind_t;

    function automatic kind_t kind_of(input logic [OP_W-1:0] op);
        kind_t k;
        case (op)
            5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b00111, 5'b01000,
            5'b01001, 5'b01010, 5'b01011: k = K_R;
            5'b01100, 5'b01101, 5'b01110: k = K_I;
            5'b10001, 5'b10010:           k = K_U;
            5'b01111, 5'b10000:           k = K_M;
            default:                      k = K_BAD;
        endcase
        return k;
    endfunction

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic               ready_q, ready_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [RADDR_W-1:0] rd_sel_q, rd_sel_d;
    logic               rd_en_q, rd_en_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic               imm_en_q, imm_en_d;
    logic               y_in_q, y_in_d;
    logic               z_in_q, z_in_d;
    logic               zlo_q, zlo_d;
    logic               zhi_q, zhi_d;
    logic [RADDR_W-1:0] wr_sel_q, wr_sel_d;
    logic               wr_en_q, wr_en_d;
    logic               lo_in_q, lo_in_d;
    logic               hi_in_q, hi_in_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    kind_t              kind_q, kind_d;
    logic [RADDR_W-1:0] ra_d, rb_d, rc_d;
    logic [IMM_W-1:0]   c_d;

    assign kind_q = kind_of(ir_q[DATA_W-1 -: OP_W]);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    ir_d = bus.instr;
                    if (kind_of(bus.instr[DATA_W-1 -: OP_W]) == K_BAD)
                        state_d = S_ERR;
                    else
                        state_d = S_T3;
                end
            end
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (kind_q == K_M) ? S_T6 : S_IDLE;
            S_T6:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they stay pure
    // functions of the registered state and instruction.
    always_comb begin
        kind_d   = kind_of(ir_d[DATA_W-1 -: OP_W]);
        ra_d     = ir_d[RA_HI -: RADDR_W];
        rb_d     = ir_d[RB_HI -: RADDR_W];
        rc_d     = ir_d[RC_HI -: RADDR_W];
        c_d      = ir_d[IMM_W-1:0];
        ready_d  = (state_d == S_IDLE);
        imm_d    = {{(DATA_W-IMM_W){c_d[IMM_W-1]}}, c_d};
        op_d     = '0;
        rd_sel_d = '0;
        rd_en_d  = 1'b0;
        imm_en_d = 1'b0;
        y_in_d   = 1'b0;
        z_in_d   = 1'b0;
        zlo_d    = 1'b0;
        zhi_d    = 1'b0;
        wr_sel_d = '0;
        wr_en_d  = 1'b0;
        lo_in_d  = 1'b0;
        hi_in_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_d)
            S_T3: begin
                rd_en_d  = 1'b1;
                y_in_d   = 1'b1;
                rd_sel_d = (kind_d == K_M) ? ra_d : rb_d;
            end
            S_T4: begin
                op_d   = ir_d[DATA_W-1 -: OP_W];
                z_in_d = 1'b1;
                if (kind_d == K_I) begin
                    imm_en_d = 1'b1;
                end else begin
                    rd_en_d  = 1'b1;
                    rd_sel_d = (kind_d == K_R) ? rc_d : rb_d;
                end
            end
            S_T5: begin
                zlo_d = 1'b1;
                if (kind_d == K_M) begin
                    lo_in_d = 1'b1;
                end else begin
                    wr_en_d  = 1'b1;
                    wr_sel_d = ra_d;
                    done_d   = 1'b1;
                end
            end
            S_T6: begin
                zhi_d   = 1'b1;
                hi_in_d = 1'b1;
                done_d  = 1'b1;
            end
            S_ERR:   err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            ready_q  <= 1'b1;
            op_q     <= '0;
            rd_sel_q <= '0;
            rd_en_q  <= 1'b0;
            imm_q    <= '0;
            imm_en_q <= 1'b0;
            y_in_q   <= 1'b0;
            z_in_q   <= 1'b0;
            zlo_q    <= 1'b0;
            zhi_q    <= 1'b0;
            wr_sel_q <= '0;
            wr_en_q  <= 1'b0;
            lo_in_q  <= 1'b0;
            hi_in_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ready_q  <= ready_d;
            op_q     <= op_d;
            rd_sel_q <= rd_sel_d;
            rd_en_q  <= rd_en_d;
            imm_q    <= imm_d;
            imm_en_q <= imm_en_d;
            y_in_q   <= y_in_d;
            z_in_q   <= z_in_d;
            zlo_q    <= zlo_d;
            zhi_q    <= zhi_d;
            wr_sel_q <= wr_sel_d;
            wr_en_q  <= wr_en_d;
            lo_in_q  <= lo_in_d;
            hi_in_q  <= hi_in_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.op_code     = op_q;
    assign bus.rd_sel      = rd_sel_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.imm_out     = imm_q;
    assign bus.imm_en      = imm_en_q;
    assign bus.y_in        = y_in_q;
    assign bus.z_in        = z_in_q;
    assign bus.zlo_out     = zlo_q;
    assign bus.zhi_out     = zhi_q;
    assign bus.wr_sel      = wr_sel_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.lo_in       = lo_in_q;
    assign bus.hi_in       = hi_in_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus queues expected per-step
// strobe bundles, a negedge monitor pops one for every busy cycle.
module tb_alu_op_sequencer;
    logic clk;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [55:0] v;
    } exp_t;

    exp_t q[$];

    // flags: {rd_en,imm_en,y_in,z_in,zlo,zhi,wr_en,lo_in,hi_in,done,err}
    function automatic logic [55:0] ev(input logic [4:0] op,
                                       input logic [3:0] rs,
                                       input logic [3:0] ws,
                                       input logic [31:0] imm,
                                       input logic [10:0] f);
        return {op, rs, f[10], f[9], imm, f[8], f[7], f[6], f[5],
                ws, f[4], f[3], f[2], f[1], f[0]};
    endfunction

    function automatic logic [55:0] snap();
        return {bus.op_code, bus.rd_sel, bus.rd_en, bus.imm_en,
                bus.imm_out, bus.y_in, bus.z_in, bus.zlo_out,
                bus.zhi_out, bus.wr_sel, bus.wr_en, bus.lo_in,
                bus.hi_in, bus.done, bus.err};
    endfunction

    task automatic push(input string n, input logic [55:0] v);
        exp_t e;
        e.name = n;
        e.v    = v;
        q.push_back(e);
    endtask

    task automatic exp_r(input string n, input logic [4:0] op,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] s4, input logic [31:0] imm);
        push({n, ".T3"}, ev(5'd0, rb, 4'd0, imm, 11'b10100000000));
        push({n, ".T4"}, ev(op, s4, 4'd0, imm, 11'b10010000000));
        push({n, ".T5"}, ev(5'd0, 4'd0, ra, imm, 11'b00001010010));
    endtask

    task automatic exp_i(input string n, input logic [4:0] op,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [31:0] imm);
        push({n, ".T3"}, ev(5'd0, rb, 4'd0, imm, 11'b10100000000));
        push({n, ".T4"}, ev(op, 4'd0, 4'd0, imm, 11'b01010000000));
        push({n, ".T5"}, ev(5'd0, 4'd0, ra, imm, 11'b00001010010));
    endtask

    task automatic exp_m(input string n, input logic [4:0] op,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [31:0] imm);
        push({n, ".T3"}, ev(5'd0, ra, 4'd0, imm, 11'b10100000000));
        push({n, ".T4"}, ev(op, rb, 4'd0, imm, 11'b10010000000));
        push({n, ".T5"}, ev(5'd0, 4'd0, 4'd0, imm, 11'b00001001000));
        push({n, ".T6"}, ev(5'd0, 4'd0, 4'd0, imm, 11'b00000100110));
    endtask

    task automatic exp_err(input string n, input logic [31:0] imm);
        push({n, ".ERR"}, ev(5'd0, 4'd0, 4'd0, imm, 11'b00000000001));
    endtask

    task automatic wait_ready(input string n);
        int i;
        i = 0;
        @(negedge clk);
        while (!bus.instr_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (!bus.instr_ready) begin
            checks++;
            errors++;
            $display("FAIL %s ready timeout got 0 want 1", n);
        end
    endtask

    task automatic issue(input string n, input logic [31:0] w);
        wait_ready(n);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
    endtask

    always @(negedge clk) begin
        if (clr) begin
            checks++;
            if ($countones({bus.rd_en, bus.imm_en,
                            bus.zlo_out, bus.zhi_out}) > 1) begin
                errors++;
                $display("FAIL bus_excl got %b want onehot0",
                         {bus.rd_en, bus.imm_en, bus.zlo_out, bus.zhi_out});
            end
            if (!bus.instr_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_busy got %h want idle", snap());
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (snap() !== e.v) begin
                        errors++;
                        $display("FAIL %s got %h want %h", e.name, snap(), e.v);
                    end
                end
            end
        end
    end

    initial begin
        int i;
        clr             = 1'b0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        #3;
        checks++;
        if (snap() !== 56'd0) begin
            errors++;
            $display("FAIL reset_outs got %h want 0", snap());
        end
        #9 clr = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", bus.instr_ready);
        end

        exp_r("add", 5'b00011, 4'd3, 4'd1, 4'd2, 32'h0001_0000);
        issue("add", 32'h1989_0000);
        exp_i("addi", 5'b01100, 4'd2, 4'd4, 32'hFFFF_FFFB);
        issue("addi", 32'h6127_FFFB);
        exp_m("mul", 5'b01111, 4'd5, 4'd6, 32'h0000_0000);
        issue("mul", 32'h7AB0_0000);
        exp_r("neg", 5'b10001, 4'd7, 4'd1, 4'd1, 32'h0000_0000);
        issue("neg", 32'h8B88_0000);
        exp_err("ld", 32'h0000_0000);
        issue("ld", 32'h0000_0000);
        exp_r("sub", 5'b00100, 4'd1, 4'd2, 4'd3, 32'h0001_8000);
        issue("sub", 32'h2091_8000);
        exp_m("div", 5'b10000, 4'd9, 4'd10, 32'h0000_0000);
        issue("div", 32'h84D0_0000);
        exp_err("op1f", 32'h0000_0000);
        issue("op1f", 32'hF800_0000);
        exp_err("op13", 32'h0000_0000);
        issue("op13", 32'h9800_0000);

        // valid held high: second word must wait until the sequencer idles
        exp_r("sub_h", 5'b00100, 4'd1, 4'd2, 4'd3, 32'h0001_8000);
        exp_m("div_h", 5'b10000, 4'd9, 4'd10, 32'h0000_0000);
        wait_ready("hold");
        bus.instr       = 32'h2091_8000;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr = 32'h84D0_0000;
        wait_ready("hold2");
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;

        // reset in T5 of a mul
        exp_m("mul_rst", 5'b01111, 4'd5, 4'd6, 32'h0000_0000);
        issue("mul_rst", 32'h7AB0_0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (bus.lo_in !== 1'b1) begin
            errors++;
            $display("FAIL mul_rst.lo_in got %b want 1", bus.lo_in);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (snap() !== 56'd0) begin
            errors++;
            $display("FAIL mid_reset_outs got %h want 0", snap());
        end
        checks++;
        if (q.size() != 2) begin
            errors++;
            $display("FAIL mul_rst.steps got %0d want 2 pending", q.size());
        end
        q.delete();
        @(negedge clk);
        #2 clr = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1 || snap() !== 56'd0) begin
            errors++;
            $display("FAIL post_reset got ready=%b outs=%h want 1/0",
                     bus.instr_ready, snap());
        end

        exp_r("add2", 5'b00011, 4'd3, 4'd1, 4'd2, 32'h0001_0000);
        issue("add2", 32'h1989_0000);

        i = 0;
        while (q.size() != 0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control-side counterpart of the ALU: accepts one 32-bit instruction word over a valid/ready handshake and decodes its opcode and register fields.
- Sequences bus-datapath strobes over steps T3–T6: operand to Y, ALU op_code plus Z latch, then Z to register file or HI/LO.
- Drives the ALU's op_code input and owns the Y/Z/register transfer timing around it. Covers ALU-class instructions only; ld/st/branch/jump belong to other control blocks.

Parameters:
- DATA_W, 32, datapath and instruction width
- OP_W, 5, opcode width, field [31:27]
- RADDR_W, 4, register index width
- IMM_W, 19, immediate field width, field [18:0]

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- instr  in  32  instruction word; ra=[26:23], rb=[22:19], rc=[18:15], C=[18:0]
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer idle, can accept
- op_code  out  5  to ALU op_code
- rd_sel  out  4  register index driven onto bus
- rd_en  out  1  register-file bus drive enable
- imm_out  out  32  sign-extended C
- imm_en  out  1  imm_out drives bus
- y_in  out  1  load Y from bus
- z_in  out  1  load Z (64-bit) from ALU c
- zlo_out  out  1  Z[31:0] onto bus
- zhi_out  out  1  Z[63:32] onto bus
- wr_sel  out  4  register index written from bus
- wr_en  out  1  register-file write enable
- lo_in  out  1  load LO from bus
- hi_in  out  1  load HI from bus
- done  out  1  one-cycle pulse in final step
- err  out  1  one-cycle pulse, illegal opcode

Behaviour:
- Opcode classes:
  - R-type ra←rb op rc: add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011.
  - I-type ra←rb op C: addi 01100, andi 01101, ori 01110.
  - U-type ra←op rb: neg 10001, not 10010.
  - M-type LO/HI←ra op rb: mul 01111, div 10000.
  - All other opcodes (incl. 00000–00010, 10011–10101, 10110–11111) are illegal.
- States: IDLE, T3, T4, T5, T6, ERR. instr is latched into an internal register on accept; all outputs are Moore, decoded from state and latched instruction only.
- IDLE: instr_ready=1. instr_valid=1 latches instr and moves to T3 (legal) or ERR (illegal). instr_valid=0 stays in IDLE.
- T3: rd_en=1, y_in=1, rd_sel=rb for R/I/U, ra for M.
- T4: op_code=latched opcode, z_in=1, and the bus source is:
  - R: rd_sel=rc, rd_en=1.
  - I: imm_en=1, imm_out={{13{C[18]}},C}.
  - U: rd_sel=rb, rd_en=1.
  - M: rd_sel=rb, rd_en=1.
- T5: zlo_out=1. R/I/U: wr_en=1, wr_sel=ra, done=1, next IDLE. M: lo_in=1, next T6.
- T6 (M only): zhi_out=1, hi_in=1, done=1, next IDLE.
- ERR: err=1 for one cycle, no strobes, next IDLE.
- Latency, accept edge to done cycle: 3 cycles for R/I/U, 4 for M, 1 to err. Next accept is possible in the cycle after done/err.
- Outside T4, op_code=00000. imm_out is always sign-extended from the latched C; imm_en is asserted only in T4 for I-type.
- No two bus drivers (rd_en, imm_en, zlo_out, zhi_out) are ever asserted together. Asserting this is a verification assertion.
- Reset (clr=0, any time, including mid-sequence): state→IDLE and instruction register→0 immediately. Every strobe, done and err=0; op_code=00000, rd_sel=wr_sel=0, imm_out=0. instr_ready=1 from the first cycle after clr deasserts. An aborted sequence is not resumed.
- instr and instr_valid are ignored outside IDLE.

Test Plan:
- add r3,r1,r2: instr=0x19890000 valid 1 cycle → T3 rd_sel=1,y_in; T4 op_code=00011,rd_sel=2,z_in; T5 zlo_out,wr_sel=3,wr_en,done; ready back next cycle.
- addi r2,r4,-5: instr=0x6127FFFB → T4 imm_en=1, imm_out=0xFFFFFFFB, op_code=01100; T5 wr_sel=2.
- mul r5,r6: instr=0x7AB00000 → T3 rd_sel=5; T4 rd_sel=6, op_code=01111; T5 lo_in, no done; T6 zhi_out, hi_in, done.
- neg r7,r1: instr=0x8B880000 → T4 rd_sel=1, op_code=10001; T5 wr_sel=7. Then ld instr=0x00000000 → err pulse 1 cycle after accept, no strobes.
- Reset mid-mul: clr low during T5 → lo_in drops asynchronously, all outputs at reset values; after release instr_ready=1. valid held high during a busy sequence is not re-accepted until IDLE.
